irq_pending_ctrl: RTL

//   Upstream request collector for the 8-to-3 priority encoder. Latches

---
 rtl/irq_pending_ctrl_pkg.sv | 17 +
 rtl/irq_pending_ctrl_pr_coder.sv | 19 +
 rtl/irq_pending_ctrl.sv | 77 +++++++
 3 files changed

// File: rtl/irq_pending_ctrl_pkg.sv
// Shared constants and helpers for the interrupt pending controller.
//   N_REQ    : request count, fixed by the 8-to-3 encoder width
//   IDX_W    : index width
//   onehot8  : index -> one-hot request vector
package irq_pending_ctrl_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_pending_ctrl_pr_coder.sv
// 8-to-3 priority encoder, highest-numbered set bit wins.
//   num : input request vector
//   idx : index of the highest set bit, 0 when num is all zero
module pr_coder
  import irq_pending_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] num,
  output logic [IDX_W-1:0] idx
);

  // Ascending scan: the last (highest) set bit overwrites earlier ones.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (num[i]) idx = i[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Request collector ahead of the interrupt/dispatch consumer.
// Captures request edges (or levels) into a pending register, filters by
// mask and global enable, and offers the highest eligible index on a
// valid/ready output. A pending bit clears when its index is loaded.
//   clk, rst_n : clock, synchronous active-low reset
//   req_in     : raw request lines
//   mask       : per-source dispatch eligibility
//   en         : global dispatch enable
//   out_valid  : out_idx holds a dispatched request
//   out_ready  : consumer accepts when out_valid & out_ready
//   out_idx    : dispatched index (7 = highest priority)
//   pending    : pending register status
//   overflow   : sticky re-fire-while-pending flags (edge mode only)
//   ovf_clr    : clear overflow flags
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  input  logic [N_REQ-1:0] mask,
  input  logic             en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] overflow,
  input  logic             ovf_clr
);

  logic [N_REQ-1:0] req_prev;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] take;
  logic [N_REQ-1:0] ovf_set;
  logic [IDX_W-1:0] enc_idx;
  logic             load;

  pr_coder u_pr_coder (
    .num (elig),
    .idx (enc_idx)
  );

  always_comb begin
    rise    = EDGE_MODE ? (req_in & ~req_prev) : req_in;
    elig    = pending & mask & {N_REQ{en}};
    // Encoder output for an all-zero vector is never used: load gates it.
    load    = (|elig) & (~out_valid | out_ready);
    take    = load ? onehot8(enc_idx) : '0;
    ovf_set = EDGE_MODE ? (rise & pending & ~take) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_prev  <= '0;
      pending   <= '0;
      overflow  <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      req_prev <= req_in;
      // A new rise on the taken bit re-arms it in the same cycle.
      pending  <= (pending & ~take) | rise;
      // Set has priority over a simultaneous clear.
      overflow <= (ovf_clr ? '0 : overflow) | ovf_set;
      if (load) begin
        out_valid <= 1'b1;
        out_idx   <= enc_idx;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
